// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, hazard classification type and small helpers for the
// ID-stage hazard scoreboard and its counter bank.
package hazard_scoreboard_pkg;

  localparam int HSB_RPORTS       = 2;
  localparam int HSB_FWD          = 3;
  localparam int HSB_DW           = 32;
  localparam int HSB_REG_NUM      = 32;
  localparam int HSB_MAX_INFLIGHT = 4;
  localparam int AW               = 5;

  // Outcome of checking one read port against the pipeline and the scoreboard
  typedef enum logic [1:0] {
    HZ_NONE  = 2'd0,
    HZ_FWD   = 2'd1,
    HZ_STALL = 2'd2
  } hz_kind_e;

  // r0 is hard-wired zero, so it never carries a dependency
  function automatic logic addr_nz(input logic [AW-1:0] a);
    return (a != {AW{1'b0}});
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter_bank.sv
// Per-register saturating counters of outstanding writes. Incremented when a
// writer leaves ID, decremented when it retires at WB, cleared on flush.
module sb_counter_bank
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_NUM      = HSB_REG_NUM,
  parameter int MAX_INFLIGHT = HSB_MAX_INFLIGHT,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               inc,
  input  logic [AW-1:0]      inc_addr,
  input  logic               dec,
  input  logic [AW-1:0]      dec_addr,
  output logic [REG_NUM-1:0] busy_vec,
  output logic               overflow
);

  logic [CW-1:0]      cnt_r [REG_NUM];
  logic               ovf_r;
  logic [REG_NUM-1:0] inc_hit_s;
  logic [REG_NUM-1:0] dec_hit_s;
  logic [REG_NUM-1:0] sat_hit_s;

  // Decode inc/dec addresses into per-register strobes and detect saturation
  always_comb begin
    inc_hit_s = {REG_NUM{1'b0}};
    dec_hit_s = {REG_NUM{1'b0}};
    sat_hit_s = {REG_NUM{1'b0}};
    for (int r = 0; r < REG_NUM; r++) begin
      inc_hit_s[r] = inc && (inc_addr == AW'(r));
      dec_hit_s[r] = dec && (dec_addr == AW'(r));
      sat_hit_s[r] = inc_hit_s[r] && !dec_hit_s[r] &&
                     (cnt_r[r] == CW'(MAX_INFLIGHT));
    end
  end

  // Counter update: a simultaneous inc and dec of one register cancel out;
  // saturated counters hold and raise the sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REG_NUM; r++) cnt_r[r] <= {CW{1'b0}};
      ovf_r <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < REG_NUM; r++) cnt_r[r] <= {CW{1'b0}};
      ovf_r <= ovf_r;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (inc_hit_s[r] && !dec_hit_s[r]) begin
          if (cnt_r[r] != CW'(MAX_INFLIGHT)) cnt_r[r] <= cnt_r[r] + CW'(1);
          else                               cnt_r[r] <= cnt_r[r];
        end else if (dec_hit_s[r] && !inc_hit_s[r]) begin
          if (cnt_r[r] != {CW{1'b0}}) cnt_r[r] <= cnt_r[r] - CW'(1);
          else                        cnt_r[r] <= cnt_r[r];
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
      ovf_r <= ovf_r | (|sat_hit_s);
    end
  end

  // Busy view straight from the counter registers
  always_comb begin
    busy_vec = {REG_NUM{1'b0}};
    for (int r = 0; r < REG_NUM; r++) begin
      busy_vec[r] = (cnt_r[r] != {CW{1'b0}});
    end
  end

  assign overflow = ovf_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: forwards operands from the youngest matching pipeline
// stage and pauses ID while a producer is not ready or still in flight in a
// unit that has no forwarding path.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_RPORTS   = HSB_RPORTS,
  parameter int NUM_FWD      = HSB_FWD,
  parameter int DW           = HSB_DW,
  parameter int REG_NUM      = HSB_REG_NUM,
  parameter int MAX_INFLIGHT = HSB_MAX_INFLIGHT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_RPORTS*AW-1:0] rf_raddr,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic [AW-1:0]            issue_waddr,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_FWD-1:0]       fwd_we,
  input  logic [NUM_FWD-1:0]       fwd_ready,
  input  logic [NUM_FWD*AW-1:0]    fwd_waddr,
  input  logic [NUM_FWD*DW-1:0]    fwd_data,
  input  logic [NUM_FWD-1:0]       int_pause,
  input  logic                     commit_valid,
  input  logic [AW-1:0]            commit_waddr,
  output logic                     pause,
  output logic [NUM_RPORTS-1:0]    rd_occur,
  output logic [NUM_RPORTS*DW-1:0] rd_fwd_data,
  output logic [REG_NUM-1:0]       busy_vec,
  output logic                     sb_overflow
);

  logic                     inc_s;
  logic                     dec_s;
  logic                     pause_s;
  logic [REG_NUM-1:0]       busy_s;
  logic                     ovf_s;
  logic [NUM_RPORTS-1:0]    stall_s;
  logic [NUM_RPORTS-1:0]    occur_s;
  logic [NUM_RPORTS*DW-1:0] data_s;

  sb_counter_bank #(
    .REG_NUM      (REG_NUM),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .inc      (inc_s),
    .inc_addr (issue_waddr),
    .dec      (dec_s),
    .dec_addr (commit_waddr),
    .busy_vec (busy_s),
    .overflow (ovf_s)
  );

  // Scoreboard strobes: only a writer that actually leaves ID is counted
  always_comb begin
    inc_s = issue_valid && !pause_s && issue_we && addr_nz(issue_waddr);
    dec_s = commit_valid && addr_nz(commit_waddr);
  end

  // Per-port classification: youngest matching stage decides forward vs stall;
  // without a match, a busy counter stalls unless the write retires this cycle
  always_comb begin
    logic [AW-1:0] a_v;
    logic          hit_v;
    int            hit_idx_v;
    hz_kind_e      kind_v;
    stall_s = {NUM_RPORTS{1'b0}};
    occur_s = {NUM_RPORTS{1'b0}};
    data_s  = {(NUM_RPORTS*DW){1'b0}};
    for (int p = 0; p < NUM_RPORTS; p++) begin
      a_v       = rf_raddr[AW*p +: AW];
      hit_v     = 1'b0;
      hit_idx_v = 0;
      kind_v    = HZ_NONE;
      for (int s = NUM_FWD - 1; s >= 0; s--) begin
        if (fwd_valid[s] && fwd_we[s] && (fwd_waddr[AW*s +: AW] == a_v)) begin
          hit_v     = 1'b1;
          hit_idx_v = s;
        end else begin
          hit_v     = hit_v;
        end
      end
      if (!addr_nz(a_v)) begin
        kind_v = HZ_NONE;
      end else if (hit_v) begin
        if (fwd_ready[hit_idx_v]) kind_v = HZ_FWD;
        else                      kind_v = HZ_STALL;
      end else if (busy_s[a_v] && !(commit_valid && (commit_waddr == a_v))) begin
        kind_v = HZ_STALL;
      end else begin
        kind_v = HZ_NONE;
      end
      case (kind_v)
        HZ_FWD: begin
          occur_s[p]           = 1'b1;
          data_s[DW*p +: DW]   = fwd_data[DW*hit_idx_v +: DW];
        end
        HZ_STALL: stall_s[p]   = 1'b1;
        HZ_NONE:  occur_s[p]   = 1'b0;
        default:  occur_s[p]   = 1'b0;
      endcase
    end
  end

  // ID pause: operand stall or interrupt-detect request from a live stage
  always_comb begin
    pause_s = ((|stall_s) || (|(int_pause & fwd_valid))) && !reset && !flush;
  end

  // Outputs read as zero while reset is asserted
  always_comb begin
    pause       = pause_s;
    rd_occur    = occur_s & {NUM_RPORTS{~reset}};
    rd_fwd_data = data_s & {(NUM_RPORTS*DW){~reset}};
    busy_vec    = busy_s & {REG_NUM{~reset}};
    sb_overflow = ovf_s;
  end

endmodule
